matrix_a_load_ctrl: RTL and testbench

MATRIX_A_LOAD_CTRL -- requirements
Module: matrix_a_load_ctrl

---
 rtl/matrix_a_load_ctrl_if.sv | 28 ++
 rtl/matrix_a_load_ctrl.sv | 107 ++++++++++
 tb/tb_matrix_a_load_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_a_load_ctrl_if.sv
// Bundle of the load-request, source-memory and matrix-A buffer signals
// of the matrix A load controller.
interface matrix_a_load_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              abort;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic              A_opcode;
  logic [31:0]       Data_to_A;
  logic              buf_rst;
  logic              busy;
  logic              done;
  logic [15:0]       load_count;

  modport master (
    input  start, base_addr, abort, mem_rd_data,
    output mem_rd_en, mem_addr, A_opcode, Data_to_A, buf_rst, busy, done, load_count
  );

  modport slave (
    output start, base_addr, abort, mem_rd_data,
    input  mem_rd_en, mem_addr, A_opcode, Data_to_A, buf_rst, busy, done, load_count
  );
endinterface

// File: rtl/matrix_a_load_ctrl.sv
// Streams `row` consecutive 32-bit words from source memory into the
// matrix A buffer; supports abort and keeps a saturating load counter.
module matrix_a_load_ctrl #(
  parameter int row    = 4,
  parameter int col    = 4,
  parameter int ADDR_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  matrix_a_load_ctrl_if.master bus
);

  localparam int unsigned     CNT_W  = $clog2(row + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(row - 1);
  // An out-of-range configuration elaborates to a block that never starts.
  localparam bit              CFG_OK = (row >= 2) && (row <= 256) && (col >= 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE,
    ABORT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       load_count_q, load_count_d;
  logic              a_opcode_q;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              done_pulse;
  logic              buf_rst_pulse;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      issue_cnt_q  <= '0;
      base_q       <= '0;
      load_count_q <= '0;
      a_opcode_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      base_q       <= base_d;
      load_count_q <= load_count_d;
      a_opcode_q   <= rd_en;
    end
  end

  always_comb begin
    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    base_d        = base_q;
    load_count_d  = load_count_q;
    rd_en         = 1'b0;
    rd_addr       = '0;
    done_pulse    = 1'b0;
    buf_rst_pulse = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort && CFG_OK) begin
          base_d      = bus.base_addr;
          issue_cnt_d = '0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // The read in the abort cycle is still issued; its word lands in ABORT.
        rd_en   = 1'b1;
        rd_addr = base_q + ADDR_W'(issue_cnt_q);
        if (bus.abort) begin
          state_d = ABORT;
        end else begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = bus.abort ? ABORT : DONE;
      end
      DONE: begin
        done_pulse = 1'b1;
        if (load_count_q != '1) load_count_d = load_count_q + 16'd1;
        state_d = IDLE;
      end
      ABORT: begin
        buf_rst_pulse = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_rd_en  = rd_en;
  assign bus.mem_addr   = rd_addr;
  assign bus.A_opcode   = a_opcode_q;
  assign bus.Data_to_A  = a_opcode_q ? bus.mem_rd_data : '0;
  assign bus.buf_rst    = buf_rst_pulse;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_pulse;
  assign bus.load_count = load_count_q;

endmodule

// File: tb/tb_matrix_a_load_ctrl.sv
// Scoreboard bench for matrix_a_load_ctrl: expected reads/writes queued by
// stimulus, popped and compared by a negedge monitor.
module tb_matrix_a_load_ctrl;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  int n_rd, n_wr, n_done, n_bufrst;
  int first_rd, first_wr, done_cyc, bufrst_cyc, idle_cyc;

  matrix_a_load_ctrl_if #(.ADDR_W(8)) bus ();

  matrix_a_load_ctrl #(.row(4), .col(4), .ADDR_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // source memory: 1-cycle read latency, data = addr + 0x100
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= 32'h100 + {24'h0, bus.mem_addr};
    else               bus.mem_rd_data <= 32'hDEADBEEF;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_rd_en) begin
        n_rd++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr.size() == 0) check("unexpected_read", {24'h0, bus.mem_addr}, 32'hFFFF_FFFF);
        else                      check("mem_addr", {24'h0, bus.mem_addr}, exp_addr.pop_front());
      end
      if (bus.A_opcode) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        if (exp_data.size() == 0) check("unexpected_write", bus.Data_to_A, 32'hFFFF_FFFF);
        else                      check("Data_to_A", bus.Data_to_A, exp_data.pop_front());
      end else begin
        check("Data_to_A_idle_zero", bus.Data_to_A, 32'h0);
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.buf_rst) begin
        n_bufrst++;
        bufrst_cyc = cyc;
      end
    end
  end

  task automatic clear_counts();
    n_rd = 0; n_wr = 0; n_done = 0; n_bufrst = 0;
    first_rd = -1; first_wr = -1; done_cyc = -1; bufrst_cyc = -1; idle_cyc = -1;
  endtask

  task automatic push_load(input logic [7:0] base, input int n_reads, input int n_writes);
    logic [7:0] a;
    for (int i = 0; i < n_reads; i++) begin
      a = base + 8'(i);
      exp_addr.push_back({24'h0, a});
      if (i < n_writes) exp_data.push_back(32'h100 + {24'h0, a});
    end
  endtask

  task automatic launch(input logic [7:0] base, output int ts);
    @(negedge clk);
    bus.base_addr = base;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    ts        = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        idle_cyc = cyc;
        return;
      end
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_queues_empty();
    check("addr_queue_empty", exp_addr.size(), 0);
    check("data_queue_empty", exp_data.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd_en"},  {31'h0, bus.mem_rd_en}, 0);
    check({tag, "_mem_addr"},   {24'h0, bus.mem_addr}, 0);
    check({tag, "_A_opcode"},   {31'h0, bus.A_opcode}, 0);
    check({tag, "_Data_to_A"},  bus.Data_to_A, 0);
    check({tag, "_buf_rst"},    {31'h0, bus.buf_rst}, 0);
    check({tag, "_busy"},       {31'h0, bus.busy}, 0);
    check({tag, "_done"},       {31'h0, bus.done}, 0);
    check({tag, "_load_count"}, {16'h0, bus.load_count}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts;
    checks = 0; errors = 0; mon_en = 1'b0;
    clear_counts();
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset  = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // single load, base 0x10
    clear_counts();
    push_load(8'h10, 4, 4);
    launch(8'h10, ts);
    wait_idle();
    check("t1_first_rd", first_rd, ts);
    check("t1_first_wr", first_wr, ts + 1);
    check("t1_reads", n_rd, 4);
    check("t1_writes", n_wr, 4);
    check("t1_done_cycle", done_cyc, ts + 5);
    check("t1_done_count", n_done, 1);
    check("t1_idle_cycle", idle_cyc, ts + 6);
    check("t1_buf_rst", n_bufrst, 0);
    check("t1_load_count", {16'h0, bus.load_count}, 1);
    check_queues_empty();

    // address wrap, base 0xFE
    clear_counts();
    push_load(8'hFE, 4, 4);
    launch(8'hFE, ts);
    wait_idle();
    check("t2_reads", n_rd, 4);
    check("t2_done_count", n_done, 1);
    check("t2_load_count", {16'h0, bus.load_count}, 2);
    check_queues_empty();

    // second start while busy is ignored
    clear_counts();
    push_load(8'h40, 4, 4);
    launch(8'h40, ts);
    @(negedge clk);
    @(negedge clk);
    bus.base_addr = 8'h80;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("t3_idle_cycle", idle_cyc, ts + 6);
    check("t3_stays_idle", {31'h0, bus.busy}, 0);
    check("t3_reads", n_rd, 4);
    check("t3_done_count", n_done, 1);
    check("t3_load_count", {16'h0, bus.load_count}, 3);
    check_queues_empty();

    // abort mid-FETCH in cycle T+2
    clear_counts();
    push_load(8'h20, 2, 2);
    launch(8'h20, ts);
    @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    wait_idle();
    check("t4_reads", n_rd, 2);
    check("t4_writes", n_wr, 2);
    check("t4_buf_rst_count", n_bufrst, 1);
    check("t4_buf_rst_cycle", bufrst_cyc, ts + 2);
    check("t4_idle_cycle", idle_cyc, ts + 3);
    check("t4_done_count", n_done, 0);
    check("t4_load_count", {16'h0, bus.load_count}, 3);
    check_queues_empty();

    // start together with abort in IDLE is rejected
    clear_counts();
    @(negedge clk);
    bus.start = 1'b1; bus.abort = 1'b1; bus.base_addr = 8'h60;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("t5_start_rejected", {31'h0, bus.busy}, 0);
    repeat (2) @(negedge clk);
    check("t5_no_reads", n_rd, 0);

    // back-to-back loads with start held high
    clear_counts();
    push_load(8'h30, 8, 8);
    @(negedge clk);
    bus.base_addr = 8'h30;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    ts            = cyc;
    bus.base_addr = 8'h34;
    while (cyc < ts + 7) begin
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    wait_idle();
    check("t6_first_rd", first_rd, ts);
    check("t6_reads", n_rd, 8);
    check("t6_writes", n_wr, 8);
    check("t6_done_count", n_done, 2);
    check("t6_idle_cycle", idle_cyc, ts + 13);
    check("t6_load_count", {16'h0, bus.load_count}, 5);
    check_queues_empty();

    // reset mid-load in cycle T+3
    clear_counts();
    push_load(8'h50, 3, 2);
    launch(8'h50, ts);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_reads", n_rd, 3);
    check("t7_writes", n_wr, 2);
    check("t7_no_done", n_done, 0);
    check("t7_no_buf_rst", n_bufrst, 0);
    check("t7_idle", {31'h0, bus.busy}, 0);
    check_queues_empty();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
